// File: rtl/flit_ejection_monitor_pkg.sv
// Shared flit encoding, error codes and FSM states for the ejection monitor.
// The head layout doubles as a generic 32-bit flit view (type bits in the same place).
package flit_ejection_monitor_pkg;

    localparam int TS_W  = 14;
    localparam int PID_W = 8;

    typedef enum logic [1:0] {
        FT_BODY = 2'b00,
        FT_HEAD = 2'b01,
        FT_TAIL = 2'b10,
        FT_ILL  = 2'b11
    } flit_type_e;

    typedef enum logic [2:0] {
        ERR_NONE       = 3'd0,
        ERR_UNEXPECTED = 3'd1,
        ERR_TRUNCATED  = 3'd2,
        ERR_MISROUTE   = 3'd3,
        ERR_ILLEGAL    = 3'd4,
        ERR_SHORT      = 3'd5,
        ERR_LONG       = 3'd6
    } err_code_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BODY,
        ST_TAIL
    } state_e;

    typedef struct packed {
        flit_type_e       ftype;   // [31:30]
        logic [TS_W-1:0]  ts;      // [29:16]
        logic [3:0]       dest_x;  // [15:12]
        logic [3:0]       dest_y;  // [11:8]
        logic [PID_W-1:0] pid;     // [7:0]
    } head_t;

endpackage

// File: rtl/flit_ejection_monitor_if.sv
// Flit channel between a router local output port and the ejection sink.
interface flit_ejection_monitor_if;
    logic [31:0] flit_in;
    logic        flit_valid;
    logic        flit_ready;

    modport master (output flit_in, flit_valid, input flit_ready);
    modport slave  (input flit_in, flit_valid, output flit_ready);
endinterface

// File: rtl/flit_stats_accum.sv
// Saturating packet/latency/error statistics with a synchronous clear that
// takes priority over any event arriving in the same cycle.
module flit_stats_accum #(
    parameter int CNT_W = 16,
    parameter int SUM_W = 32,
    parameter int LAT_W = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             pkt_inc,
    input  logic [LAT_W-1:0] latency,
    input  logic             err_inc,
    output logic [CNT_W-1:0] pkt_count,
    output logic [SUM_W-1:0] lat_sum,
    output logic [LAT_W-1:0] lat_max,
    output logic [CNT_W-1:0] err_count
);

    localparam int               SUM_X   = SUM_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SUM_W:0] sum_ext;

    // One spare bit catches the carry so the sum can clamp at all-ones.
    assign sum_ext = {1'b0, lat_sum} + SUM_X'(latency);

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_count <= '0;
            lat_sum   <= '0;
            lat_max   <= '0;
            err_count <= '0;
        end else if (clear) begin
            pkt_count <= '0;
            lat_sum   <= '0;
            lat_max   <= '0;
            err_count <= '0;
        end else begin
            if (pkt_inc) begin
                if (pkt_count != '1)
                    pkt_count <= pkt_count + CNT_ONE;
                lat_sum <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
                if (latency > lat_max)
                    lat_max <= latency;
            end
            if (err_inc && err_count != '1)
                err_count <= err_count + CNT_ONE;
        end
    end

endmodule

// File: rtl/flit_ejection_monitor.sv
// Ejection-side sink: checks packet framing and destination, measures head-to-tail
// latency against a free-running timestamp, and reports pulses plus statistics.
module flit_ejection_monitor
    import flit_ejection_monitor_pkg::*;
#(
    parameter int MY_X       = 0,
    parameter int MY_Y       = 0,
    parameter int BODY_FLITS = 2,
    parameter int CNT_W      = 16,
    parameter int SUM_W      = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    flit_ejection_monitor_if.slave  flit,
    input  logic                    sink_stall,
    input  logic                    clear_stats,
    output logic                    pkt_done,
    output logic [PID_W-1:0]        pkt_pid,
    output logic [TS_W-1:0]         pkt_latency,
    output logic [CNT_W-1:0]        pkt_count,
    output logic [SUM_W-1:0]        lat_sum,
    output logic [TS_W-1:0]         lat_max,
    output logic                    err_pulse,
    output logic [2:0]              err_code,
    output logic [CNT_W-1:0]        err_count
);

    localparam logic [3:0] MY_X4     = 4'(MY_X);
    localparam logic [3:0] MY_Y4     = 4'(MY_Y);
    localparam logic [4:0] BODY_LAST = 5'(BODY_FLITS);

    state_e           state, state_nxt;
    logic [3:0]       bcnt, bcnt_nxt;
    logic [TS_W-1:0]  ts_cnt;
    logic [TS_W-1:0]  head_ts;
    logic [PID_W-1:0] head_pid;
    logic             head_misrouted;

    head_t            fl;
    logic             xfer;
    logic             dest_bad;
    logic             load_head;
    logic             done_evt;
    logic             err_evt;
    err_code_e        err_nxt;
    logic [TS_W-1:0]  cur_latency;

    assign flit.flit_ready = ~sink_stall;
    assign xfer            = flit.flit_valid & ~sink_stall;
    assign fl              = head_t'(flit.flit_in);
    assign dest_bad        = (fl.dest_x != MY_X4) || (fl.dest_y != MY_Y4);
    assign cur_latency     = ts_cnt - head_ts;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        bcnt_nxt  = bcnt;
        load_head = 1'b0;
        done_evt  = 1'b0;
        err_evt   = 1'b0;
        err_nxt   = ERR_NONE;
        if (xfer) begin
            case (fl.ftype)
                FT_HEAD: begin
                    // A head always starts a packet; truncation outranks misroute.
                    load_head = 1'b1;
                    bcnt_nxt  = '0;
                    state_nxt = (BODY_FLITS == 0) ? ST_TAIL : ST_BODY;
                    if (state != ST_IDLE) begin
                        err_evt = 1'b1;
                        err_nxt = ERR_TRUNCATED;
                    end else if (dest_bad) begin
                        err_evt = 1'b1;
                        err_nxt = ERR_MISROUTE;
                    end
                end
                FT_BODY: begin
                    case (state)
                        ST_IDLE: begin
                            err_evt = 1'b1;
                            err_nxt = ERR_UNEXPECTED;
                        end
                        ST_BODY: begin
                            bcnt_nxt = bcnt + 4'd1;
                            if (({1'b0, bcnt} + 5'd1) == BODY_LAST)
                                state_nxt = ST_TAIL;
                        end
                        default: begin
                            err_evt = 1'b1;
                            err_nxt = ERR_LONG;
                        end
                    endcase
                end
                FT_TAIL: begin
                    case (state)
                        ST_IDLE: begin
                            err_evt = 1'b1;
                            err_nxt = ERR_UNEXPECTED;
                        end
                        ST_BODY: begin
                            err_evt   = 1'b1;
                            err_nxt   = ERR_SHORT;
                            state_nxt = ST_IDLE;
                        end
                        default: begin
                            done_evt  = ~head_misrouted;
                            state_nxt = ST_IDLE;
                        end
                    endcase
                end
                default: begin
                    err_evt = 1'b1;
                    err_nxt = ERR_ILLEGAL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            bcnt           <= '0;
            ts_cnt         <= '0;
            head_ts        <= '0;
            head_pid       <= '0;
            head_misrouted <= 1'b0;
        end else begin
            state  <= state_nxt;
            bcnt   <= bcnt_nxt;
            ts_cnt <= ts_cnt + 14'd1;
            if (load_head) begin
                head_ts        <= fl.ts;
                head_pid       <= fl.pid;
                head_misrouted <= dest_bad;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_done    <= 1'b0;
            pkt_pid     <= '0;
            pkt_latency <= '0;
            err_pulse   <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            pkt_done  <= done_evt;
            err_pulse <= err_evt;
            if (done_evt) begin
                pkt_pid     <= head_pid;
                pkt_latency <= cur_latency;
            end
            if (err_evt)
                err_code <= err_nxt;
        end
    end

    flit_stats_accum #(
        .CNT_W (CNT_W),
        .SUM_W (SUM_W),
        .LAT_W (TS_W)
    ) u_stats (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear_stats),
        .pkt_inc   (done_evt),
        .latency   (cur_latency),
        .err_inc   (err_evt),
        .pkt_count (pkt_count),
        .lat_sum   (lat_sum),
        .lat_max   (lat_max),
        .err_count (err_count)
    );

endmodule

// File: tb/tb_flit_ejection_monitor.sv
// Directed bench for flit_ejection_monitor: stimulus pushes expected events into a
// scoreboard queue, a negedge monitor pops and compares on every pkt_done/err_pulse.
module tb_flit_ejection_monitor;
    import flit_ejection_monitor_pkg::*;

    localparam int MY_X       = 2;
    localparam int MY_Y       = 1;
    localparam int BODY_FLITS = 2;
    localparam int CNT_W      = 16;
    localparam int SUM_W      = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             sink_stall = 1'b0;
    logic             clear_stats = 1'b0;
    logic             pkt_done;
    logic [7:0]       pkt_pid;
    logic [13:0]      pkt_latency;
    logic [CNT_W-1:0] pkt_count;
    logic [SUM_W-1:0] lat_sum;
    logic [13:0]      lat_max;
    logic             err_pulse;
    logic [2:0]       err_code;
    logic [CNT_W-1:0] err_count;

    flit_ejection_monitor_if fif ();

    flit_ejection_monitor #(
        .MY_X(MY_X), .MY_Y(MY_Y), .BODY_FLITS(BODY_FLITS), .CNT_W(CNT_W), .SUM_W(SUM_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flit        (fif),
        .sink_stall  (sink_stall),
        .clear_stats (clear_stats),
        .pkt_done    (pkt_done),
        .pkt_pid     (pkt_pid),
        .pkt_latency (pkt_latency),
        .pkt_count   (pkt_count),
        .lat_sum     (lat_sum),
        .lat_max     (lat_max),
        .err_pulse   (err_pulse),
        .err_code    (err_code),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    // Bench-side view of the timestamp, so heads and tails can be placed at exact ts values.
    logic [13:0] model_ts;
    always @(posedge clk or posedge reset) begin
        if (reset) model_ts <= '0;
        else       model_ts <= model_ts + 14'd1;
    end

    typedef struct {
        bit          is_err;
        logic [2:0]  code;
        logic [7:0]  pid;
        logic [13:0] lat;
        logic [15:0] pc;
        logic [31:0] ls;
        logic [13:0] lm;
        logic [15:0] ec;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    endtask

    task automatic expect_ev(input bit is_err, input logic [2:0] code, input logic [7:0] pid,
                             input logic [13:0] lat, input logic [15:0] pc, input logic [31:0] ls,
                             input logic [13:0] lm, input logic [15:0] ec);
        exp_t e;
        e.is_err = is_err; e.code = code; e.pid = pid; e.lat = lat;
        e.pc = pc; e.ls = ls; e.lm = lm; e.ec = ec;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] mk(input flit_type_e t, input logic [13:0] ts,
                                       input logic [3:0] dx, input logic [3:0] dy,
                                       input logic [7:0] pid);
        head_t h;
        h.ftype = t; h.ts = ts; h.dest_x = dx; h.dest_y = dy; h.pid = pid;
        return h;
    endfunction

    function automatic logic [31:0] hd(input logic [13:0] ts, input logic [7:0] pid);
        return mk(FT_HEAD, ts, 4'(MY_X), 4'(MY_Y), pid);
    endfunction

    localparam logic [31:0] BD = 32'h0000_A5A5;
    localparam logic [31:0] TL = 32'h8000_5A5A;
    localparam logic [31:0] IL = 32'hC000_0000;

    task automatic send(input logic [31:0] f);
        fif.flit_in    = f;
        fif.flit_valid = 1'b1;
        @(posedge clk);
        #1;
        fif.flit_valid = 1'b0;
    endtask

    task automatic wait_ts(input logic [13:0] t);
        int n = 0;
        while (model_ts != t && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (model_ts != t) begin
            n_checks++;
            $display("FAIL wait_ts: ts=0x%0h, want 0x%0h", model_ts, t);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && (pkt_done || err_pulse)) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_event: done=%0b err=%0b code=%0d pid=0x%0h",
                         pkt_done, err_pulse, err_code, pkt_pid);
            end else begin
                mon_e = sb.pop_front();
                check("event_kind", {30'd0, pkt_done, err_pulse}, mon_e.is_err ? 32'd1 : 32'd2);
                check("err_code",    32'(err_code),    32'(mon_e.code));
                check("pkt_pid",     32'(pkt_pid),     32'(mon_e.pid));
                check("pkt_latency", 32'(pkt_latency), 32'(mon_e.lat));
                check("pkt_count",   32'(pkt_count),   32'(mon_e.pc));
                check("lat_sum",     lat_sum,          mon_e.ls);
                check("lat_max",     32'(lat_max),     32'(mon_e.lm));
                check("err_count",   32'(err_count),   32'(mon_e.ec));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fif.flit_in    = '0;
        fif.flit_valid = 1'b0;
        #23 reset = 1'b0;

        // Timestamp wrap: head ts 0x3FFE, tail at ts 3 -> latency 5.
        wait_ts(14'd0);
        send(hd(14'h3FFE, 8'h11)); send(BD); send(BD);
        wait_ts(14'd3);
        expect_ev(0, 3'd0, 8'h11, 14'd5, 16'd1, 32'd5, 14'd5, 16'd0);
        send(TL);

        // Plain packet: head ts 0x10, tail at ts 0x19 -> latency 9.
        wait_ts(14'h10);
        send(hd(14'h0010, 8'h05)); send(BD); send(BD);
        wait_ts(14'h19);
        expect_ev(0, 3'd0, 8'h05, 14'd9, 16'd2, 32'd14, 14'd9, 16'd0);
        send(TL);

        // Body in IDLE, then a short packet.
        expect_ev(1, 3'd1, 8'h05, 14'd9, 16'd2, 32'd14, 14'd9, 16'd1);
        send(BD);
        send(hd(14'd0, 8'h22)); send(BD);
        expect_ev(1, 3'd5, 8'h05, 14'd9, 16'd2, 32'd14, 14'd9, 16'd2);
        send(TL);

        // Truncation by a new head, which then completes.
        send(hd(14'd0, 8'h06)); send(BD);
        wait_ts(14'd32);
        expect_ev(1, 3'd2, 8'h05, 14'd9, 16'd2, 32'd14, 14'd9, 16'd3);
        send(hd(14'h0020, 8'h07)); send(BD); send(BD);
        wait_ts(14'd35);
        expect_ev(0, 3'd2, 8'h07, 14'd3, 16'd3, 32'd17, 14'd9, 16'd3);
        send(TL);

        // Truncating head that is also misrouted (wrong Y): one error, code 2; its tail is silent.
        send(hd(14'd0, 8'h08)); send(BD);
        expect_ev(1, 3'd2, 8'h07, 14'd3, 16'd3, 32'd17, 14'd9, 16'd4);
        send(mk(FT_HEAD, 14'd0, 4'(MY_X), 4'(MY_Y + 1), 8'h09)); send(BD); send(BD); send(TL);

        // Misroute in X: error at head, no completion.
        expect_ev(1, 3'd3, 8'h07, 14'd3, 16'd3, 32'd17, 14'd9, 16'd5);
        send(mk(FT_HEAD, 14'd0, 4'(MY_X + 1), 4'(MY_Y), 8'h0F)); send(BD); send(BD); send(TL);

        // Extra body in TAIL -> LONG, packet still completes.
        wait_ts(14'd46);
        send(hd(14'd46, 8'h0A)); send(BD); send(BD);
        expect_ev(1, 3'd6, 8'h07, 14'd3, 16'd3, 32'd17, 14'd9, 16'd6);
        send(BD);
        wait_ts(14'd50);
        expect_ev(0, 3'd6, 8'h0A, 14'd4, 16'd4, 32'd21, 14'd9, 16'd6);
        send(TL);

        // Illegal type in IDLE and mid-packet; state is unchanged.
        expect_ev(1, 3'd4, 8'h0A, 14'd4, 16'd4, 32'd21, 14'd9, 16'd7);
        send(IL);
        wait_ts(14'd52);
        send(hd(14'd52, 8'h0B));
        expect_ev(1, 3'd4, 8'h0A, 14'd4, 16'd4, 32'd21, 14'd9, 16'd8);
        send(IL); send(BD); send(BD);
        wait_ts(14'd56);
        expect_ev(0, 3'd4, 8'h0B, 14'd4, 16'd5, 32'd25, 14'd9, 16'd8);
        send(TL);

        // Large latency through wrap raises lat_max.
        wait_ts(14'd57);
        send(hd(14'h0100, 8'h0C)); send(BD); send(BD);
        wait_ts(14'd60);
        expect_ev(0, 3'd4, 8'h0C, 14'h3F3C, 16'd6, 32'd16213, 14'h3F3C, 16'd8);
        send(TL);

        // clear_stats coinciding with a completion: pulse appears, stats cleared, event uncounted.
        wait_ts(14'd61);
        send(hd(14'd61, 8'h0D)); send(BD); send(BD);
        wait_ts(14'd64);
        expect_ev(0, 3'd4, 8'h0D, 14'd3, 16'd0, 32'd0, 14'd0, 16'd0);
        clear_stats = 1'b1;
        send(TL);
        clear_stats = 1'b0;
        expect_ev(1, 3'd1, 8'h0D, 14'd3, 16'd0, 32'd0, 14'd0, 16'd1);
        send(BD);

        // Back-pressure: body held valid for 3 stalled cycles must not be taken.
        wait_ts(14'd66);
        send(hd(14'd66, 8'h0E));
        sink_stall     = 1'b1;
        fif.flit_in    = BD;
        fif.flit_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("stall_ready", 32'(fif.flit_ready), 32'd0);
        end
        sink_stall = 1'b0;
        @(posedge clk);
        #1;
        fif.flit_valid = 1'b0;
        send(BD);
        wait_ts(14'd72);
        expect_ev(0, 3'd1, 8'h0E, 14'd6, 16'd1, 32'd6, 14'd6, 16'd1);
        send(TL);

        // Asynchronous reset mid-packet: outputs clear without a clock edge.
        send(hd(14'd0, 8'h10)); send(BD);
        #2 reset = 1'b1;
        #1;
        check("rst_pulses",      {30'd0, pkt_done, err_pulse}, 32'd0);
        check("rst_pkt_pid",     32'(pkt_pid),     32'd0);
        check("rst_pkt_latency", 32'(pkt_latency), 32'd0);
        check("rst_err_code",    32'(err_code),    32'd0);
        check("rst_pkt_count",   32'(pkt_count),   32'd0);
        check("rst_lat_sum",     lat_sum,          32'd0);
        check("rst_lat_max",     32'(lat_max),     32'd0);
        check("rst_err_count",   32'(err_count),   32'd0);
        sink_stall = 1'b1;
        #1 check("rst_ready_stalled", 32'(fif.flit_ready), 32'd0);
        sink_stall = 1'b0;
        #1 check("rst_ready", 32'(fif.flit_ready), 32'd1);
        #1 reset = 1'b0;

        // Clean packet after reset: FSM must be back in IDLE.
        wait_ts(14'd2);
        send(hd(14'd1, 8'h55)); send(BD); send(BD);
        wait_ts(14'd5);
        expect_ev(0, 3'd0, 8'h55, 14'd4, 16'd1, 32'd4, 14'd4, 16'd0);
        send(TL);

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
